// File: rtl/hop_ctrl.sv
// Button conditioning and hop sequencer: debounces the move button, meters each
// accepted hop out as frame-locked pixel strobes, and tracks scroll offset and hop count.
module hop_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned STEP_PX         = 30,
  parameter int unsigned WRAP_PX         = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_btn,
  input  logic       frame_tick,
  output logic       hop_pulse,
  output logic       px_strobe,
  output logic       busy,
  output logic [9:0] y_offset,
  output logic [7:0] hop_count
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned REM_W = (STEP_PX > 1) ? $clog2(STEP_PX + 1) : 1;

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t             state, state_nx;
  logic               sync1, btn_sync, btn_stable, stable_d;
  logic [CNT_W-1:0]   db_cnt;
  logic [REM_W-1:0]   remaining, remaining_nx;
  logic               pending, pending_nx;
  logic               press_c, start_c, last_px_c;

  // Two-flop synchronizer followed by a level-hold debouncer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      btn_sync   <= 1'b0;
      btn_stable <= 1'b0;
      stable_d   <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync1    <= move_btn;
      btn_sync <= sync1;
      stable_d <= btn_stable;
      if (btn_sync == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_stable <= btn_sync;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  assign press_c   = btn_stable & ~stable_d;
  assign busy      = (state == SCROLL);
  assign px_strobe = frame_tick & (state == SCROLL) & ~reset;
  assign last_px_c = px_strobe & (remaining == REM_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      pending   <= pending_nx;
    end
  end

  // A press landing on the final strobe chains straight into the next hop
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    pending_nx   = pending;
    start_c      = 1'b0;
    case (state)
      IDLE: begin
        if (press_c) begin
          state_nx     = SCROLL;
          remaining_nx = REM_W'(STEP_PX);
          start_c      = 1'b1;
        end
      end
      SCROLL: begin
        if (px_strobe) remaining_nx = remaining - REM_W'(1);
        if (last_px_c) begin
          if (pending || press_c) begin
            pending_nx   = 1'b0;
            remaining_nx = REM_W'(STEP_PX);
            start_c      = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else if (press_c) begin
          pending_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hop_pulse <= 1'b0;
      hop_count <= '0;
      y_offset  <= '0;
    end else begin
      hop_pulse <= start_c;
      if (start_c && (hop_count != 8'hFF)) hop_count <= hop_count + 8'd1;
      if (px_strobe) begin
        if (y_offset == 10'(WRAP_PX - 1)) y_offset <= '0;
        else                              y_offset <= y_offset + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_hop_ctrl.sv
// Bench for hop_ctrl: hop-level reference model feeds an event scoreboard that a
// negedge monitor drains whenever the DUT pulses hop_pulse or px_strobe.
module tb_hop_ctrl;

  localparam int unsigned DB   = 4;
  localparam int unsigned STEP = 3;
  localparam int unsigned WRAP = 5;

  logic       clk = 1'b0;
  logic       reset, move_btn, frame_tick;
  logic       hop_pulse, px_strobe, busy;
  logic [9:0] y_offset;
  logic [7:0] hop_count;

  always #5 clk = ~clk;

  hop_ctrl #(.DEBOUNCE_CYCLES(DB), .STEP_PX(STEP), .WRAP_PX(WRAP)) dut (
    .clk(clk), .reset(reset), .move_btn(move_btn), .frame_tick(frame_tick),
    .hop_pulse(hop_pulse), .px_strobe(px_strobe), .busy(busy),
    .y_offset(y_offset), .hop_count(hop_count)
  );

  typedef struct {
    int cyc;
    bit pulse;
    bit strobe;
    bit busy;
    int y;
    int cnt;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: raw sample history, hops owed, pixels left, totals
  bit hist[$];
  bit m_stable, m_press, m_pulse;
  int owed, left, total_px, started;

  function automatic void model_reset();
    hist.delete();
    m_stable = 0; m_press = 0; m_pulse = 0;
    owed = 0; left = 0; total_px = 0; started = 0;
  endfunction

  function automatic void start_hop();
    m_pulse = 1;
    started++;
    left = STEP;
  endfunction

  // Advance the model across one clock edge given the inputs that edge sampled
  function automatic void model_edge(bit btn, bit ft);
    bit strobe, flip, v;
    strobe  = ft && (owed > 0);
    m_pulse = 0;
    if (m_press) begin
      if (owed == 0) begin
        owed = 1;
        start_hop();
      end else if (owed == 1) begin
        owed = 2;
      end
    end
    if (strobe) begin
      total_px++;
      left--;
      if (left == 0) begin
        owed--;
        if (owed > 0) start_hop();
      end
    end
    // a new level is accepted once the DB sync samples before this edge all differ
    hist.push_front(btn);
    if (hist.size() > DB + 2) void'(hist.pop_back());
    flip = 1;
    for (int k = 2; k < DB + 2; k++) begin
      v = (k < hist.size()) ? hist[k] : 1'b0;
      if (v == m_stable) flip = 0;
    end
    m_press = flip && !m_stable;
    if (flip) m_stable = !m_stable;
  endfunction

  function automatic void model_emit(bit ft);
    ev_t e;
    bit  strobe;
    strobe = ft && (owed > 0);
    if (m_pulse || strobe) begin
      e.cyc    = cyc;
      e.pulse  = m_pulse;
      e.strobe = strobe;
      e.busy   = (owed > 0);
      e.y      = total_px % WRAP;
      e.cnt    = (started > 255) ? 255 : started;
      exp_q.push_back(e);
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hop_pulse"}, int'(hop_pulse), 0);
    chk({tag, "_px_strobe"}, int'(px_strobe), 0);
    chk({tag, "_busy"},      int'(busy),      0);
    chk({tag, "_y_offset"},  int'(y_offset),  0);
    chk({tag, "_hop_count"}, int'(hop_count), 0);
  endtask

  task automatic step(input bit btn, input bit ft);
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else       model_edge(move_btn, frame_tick);
    move_btn   = btn;
    frame_tick = ft;
    if (!reset) model_emit(ft);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2;
    reset      = 1'b1;
    frame_tick = 1'b1;
    while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
    model_reset();
    #1;
    chk_zero(tag);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    #1;
    chk({tag, "_strobe_in_reset"}, int'(px_strobe), 0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    move_btn   = 1'b0;
    frame_tick = 1'b0;
    model_reset();
  endtask

  // Scoreboard monitor: every DUT pulse must match the next expected event
  always @(negedge clk) begin
    ev_t e;
    bit  has;
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_event cyc=%0d expected pulse=%0b strobe=%0b", e.cyc, e.pulse, e.strobe);
      end
      has = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (has || hop_pulse || px_strobe) begin
        checks++;
        if (!has) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d actual pulse=%0b strobe=%0b required none",
                   cyc, hop_pulse, px_strobe);
        end else begin
          e = exp_q.pop_front();
          if (hop_pulse !== e.pulse || px_strobe !== e.strobe || busy !== e.busy ||
              int'(y_offset) != e.y || int'(hop_count) != e.cnt) begin
            failures++;
            $display("FAIL event cyc=%0d actual p=%0b s=%0b b=%0b y=%0d n=%0d required p=%0b s=%0b b=%0b y=%0d n=%0d",
                     cyc, hop_pulse, px_strobe, busy, y_offset, hop_count,
                     e.pulse, e.strobe, e.busy, e.y, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    bit lvl;
    int run;
    lvl = 0;
    run = 0;
    reset      = 1'b1;
    move_btn   = 1'b0;
    frame_tick = 1'b0;
    model_reset();
    #3;
    chk_zero("init");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // clean press held 20 cycles, frame tick every 10
    for (int i = 0; i < 60; i++) step(i < 20, (i % 10) == 9);
    chk("clean_hop_count", int'(hop_count), 1);
    chk("clean_y_offset",  int'(y_offset),  3);
    chk("clean_busy",      int'(busy),      0);

    // bounce: five 3-cycle pulses with 2-cycle gaps
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 5; i++) step(i < 3, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("bounce_hop_count", int'(hop_count), 1);
    chk("bounce_y_offset",  int'(y_offset),  3);
    for (int i = 0; i < 40; i++) step(i < 10, (i % 4) == 3);
    chk("after_bounce_hop_count", int'(hop_count), 2);
    chk("after_bounce_y_offset",  int'(y_offset),  1);

    // overlapping presses while a hop scrolls
    for (int i = 0; i < 80; i++)
      step((i < 6) || (i >= 10 && i < 15) || (i >= 19 && i < 24), (i % 6) == 5);

    // randomized button runs and frame ticks
    for (int i = 0; i < 2500; i++) begin
      if (run == 0) begin
        lvl = !lvl;
        run = int'($urandom_range(1, 14));
      end
      run--;
      step(lvl, $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);

    // reset between the first and second strobe of a hop
    pulse_reset("rst_a");
    for (int i = 0; i < 16; i++) step(i < 8, i == 14);
    pulse_reset("rst_mid");
    for (int i = 0; i < 30; i++) step(1'b0, (i % 3) == 0);
    chk("post_reset_hop_count", int'(hop_count), 0);

    // saturation: 260 hops with a tick every cycle
    pulse_reset("rst_b");
    for (int h = 0; h < 260; h++)
      for (int i = 0; i < 12; i++) step(i < 6, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    chk("sat_hop_count", int'(hop_count), 255);
    chk("sat_y_offset",  int'(y_offset),  (260 * STEP) % WRAP);

    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
